uart_autobaud: RTL and testbench

- Baud-tick source for the UART receive path.
- Generates the single-cycle en_16x_baud pulse consumed by the UART receiver top level, using a programmable divisor.
- Can measure the incoming bit rate from a 0x55 sync character on the serial line and load the divisor from that measurement.
- Sits directly upstream of the receiver; its serial input taps the same pin.

---
 rtl/uart_autobaud.sv | 137 +++++++++++++
 tb/tb_uart_autobaud.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud.sv
// uart_autobaud: 16x baud tick generator with divisor measured from a 0x55 sync character
// Ports: clk, rst (sync, active-high); serial_in_i raw serial line; start_polarity_i line inversion;
//   autobaud_start_i arms a measurement; div_load_i/div_value_i manual divisor load;
//   en_16x_baud_o one-cycle tick; div_o active divisor; locked_o divisor came from measurement;
//   busy_o measurement in progress; timeout_o one-cycle pulse on measurement overflow.
// Optional: define UART_AUTOBAUD_GLITCH_FILTER_EN to add a 3-sample majority filter on the synchronised line.
module uart_autobaud #(
  parameter int CNT_W = 16,
  parameter int DEFAULT_DIV = 27,
  parameter int MIN_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in_i,
  input  logic             start_polarity_i,
  input  logic             autobaud_start_i,
  input  logic             div_load_i,
  input  logic [CNT_W-1:0] div_value_i,
  output logic             en_16x_baud_o,
  output logic [CNT_W-1:0] div_o,
  output logic             locked_o,
  output logic             busy_o,
  output logic             timeout_o
);
  localparam int T_W = CNT_W + 7;
  typedef enum logic [2:0] {IDLE, WAIT_IDLE, WAIT_START, MEASURE, DONE} state_t;
  state_t st_q, st_d;
  logic s1_q, s2_q, ln_q, ln, fall, src, ld;
  logic [CNT_W-1:0] div_q, div_d, cnt_q, cnt_d, man_div, meas_div;
  logic [T_W-1:0] t_q, t_d;
  logic [T_W:0] t_sum;
  logic [CNT_W:0] t_div;
  logic [2:0] e_q, e_d;
  logic locked_q, locked_d, en_q, en_d, to_q, to_d, wrap;
`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
  logic f1_q, f2_q;
  always_ff @(posedge clk)
    if (rst) begin
      f1_q <= ~start_polarity_i;
      f2_q <= ~start_polarity_i;
    end else begin
      f1_q <= s2_q;
      f2_q <= f1_q;
    end
  // Majority of three consecutive samples: a lone one-cycle glitch never wins a vote
  assign src = (s2_q & f1_q) | (s2_q & f2_q) | (f1_q & f2_q);
`else
  assign src = s2_q;
`endif
  assign ln = src ^ start_polarity_i;
  assign fall = ln_q & ~ln;
  // Round T/128 to nearest; the extra top bit catches results that exceed the divisor width
  assign t_sum = {1'b0, t_q} + (T_W+1)'(64);
  assign t_div = (CNT_W+1)'(t_sum >> 7);
  assign meas_div = t_div[CNT_W] ? '1 :
                    (t_div[CNT_W-1:0] < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : t_div[CNT_W-1:0];
  assign man_div = (div_value_i < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_value_i;
  assign ld = div_load_i | (st_q == DONE);
  assign wrap = cnt_q >= div_q - 1'b1;
  always_comb begin
    st_d = st_q;
    div_d = div_q;
    t_d = t_q;
    e_d = e_q;
    locked_d = locked_q;
    to_d = 1'b0;
    case (st_q)
      IDLE: ;
      WAIT_IDLE: st_d = ln ? WAIT_START : WAIT_IDLE;
      WAIT_START: if (fall) begin
        st_d = MEASURE;
        t_d = '0;
        e_d = '0;
      end
      MEASURE: begin
        t_d = t_q + 1'b1;
        if (&t_q) begin
          to_d = 1'b1;
          locked_d = 1'b0;
          st_d = IDLE;
        end else if (fall) begin
          e_d = e_q + 1'b1;
          st_d = (e_q == 3'd3) ? DONE : MEASURE;
        end
      end
      DONE: begin
        div_d = meas_div;
        locked_d = 1'b1;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    if (autobaud_start_i) begin
      st_d = WAIT_IDLE;
      to_d = 1'b0;
    end
    if (div_load_i) begin
      div_d = man_div;
      locked_d = 1'b0;
      st_d = IDLE;
      to_d = 1'b0;
    end
    cnt_d = (ld | wrap) ? '0 : cnt_q + 1'b1;
    en_d = ~ld & wrap;
  end
  always_ff @(posedge clk)
    if (rst) begin
      st_q <= IDLE;
      s1_q <= ~start_polarity_i;
      s2_q <= ~start_polarity_i;
      ln_q <= 1'b1;
      div_q <= CNT_W'(DEFAULT_DIV);
      cnt_q <= '0;
      t_q <= '0;
      e_q <= '0;
      locked_q <= 1'b0;
      en_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      st_q <= st_d;
      s1_q <= serial_in_i;
      s2_q <= s1_q;
      ln_q <= ln;
      div_q <= div_d;
      cnt_q <= cnt_d;
      t_q <= t_d;
      e_q <= e_d;
      locked_q <= locked_d;
      en_q <= en_d;
      to_q <= to_d;
    end
  assign en_16x_baud_o = en_q;
  assign div_o = div_q;
  assign locked_o = locked_q;
  assign busy_o = (st_q == WAIT_IDLE) | (st_q == WAIT_START) | (st_q == MEASURE);
  assign timeout_o = to_q;
endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: scoreboard bench for the baud tick generator and autobaud measurement
module tb_uart_autobaud;
  logic clk = 1'b0, rst = 1'b1;
  logic ser = 1'b1, pol = 1'b0, ab = 1'b0, ld = 1'b0;
  logic [15:0] dv = '0;
  logic en, locked, busy, to;
  logic [15:0] divo;
  logic ser4 = 1'b1, ab4 = 1'b0;
  logic en4, locked4, busy4, to4;
  logic [3:0] div4;
  int vec = 0, bad = 0;
  int exp_q[$];
  int obs_q[$];
  always #5 clk = ~clk;
  uart_autobaud dut (
    .clk(clk), .rst(rst), .serial_in_i(ser), .start_polarity_i(pol),
    .autobaud_start_i(ab), .div_load_i(ld), .div_value_i(dv),
    .en_16x_baud_o(en), .div_o(divo), .locked_o(locked), .busy_o(busy), .timeout_o(to)
  );
  uart_autobaud #(.CNT_W(4), .DEFAULT_DIV(5)) u4 (
    .clk(clk), .rst(rst), .serial_in_i(ser4), .start_polarity_i(1'b0),
    .autobaud_start_i(ab4), .div_load_i(1'b0), .div_value_i(4'd0),
    .en_16x_baud_o(en4), .div_o(div4), .locked_o(locked4), .busy_o(busy4), .timeout_o(to4)
  );
  task automatic wait_tick(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!en && c < 1000);
  endtask
  task automatic collect(input int n);
    int c;
    obs_q.delete();
    wait_tick(c);
    for (int i = 0; i < n; i++) begin
      wait_tick(c);
      obs_q.push_back(c);
    end
  endtask
  task automatic compare_periods(input string nm);
    int e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      vec++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s period: got %0d expected %0d", nm, o, e);
      end
    end
  endtask
  task automatic send_frame(input int b, input logic [7:0] d);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser = fr[i] ^ pol;
      repeat (b) @(negedge clk);
    end
    ser = ~pol;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vec += 5;
    if (divo !== 16'd27) begin bad++; $display("FAIL reset div: got %0d expected 27", divo); end
    if (locked !== 1'b0) begin bad++; $display("FAIL reset locked: got %b expected 0", locked); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b expected 0", busy); end
    if (to !== 1'b0) begin bad++; $display("FAIL reset timeout: got %b expected 0", to); end
    if (en !== 1'b0) begin bad++; $display("FAIL reset en: got %b expected 0", en); end
    repeat (3) exp_q.push_back(27);
    collect(3);
    compare_periods("reset");
  endtask
  task automatic test_manual_load;
    int k;
    ld = 1'b1;
    dv = 16'd10;
    @(negedge clk);
    ld = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!en && k < 100);
    vec += 2;
    if (k !== 10) begin bad++; $display("FAIL load first tick: got %0d cycles expected 10", k); end
    if (divo !== 16'd10) begin bad++; $display("FAIL load div: got %0d expected 10", divo); end
    repeat (3) exp_q.push_back(10);
    collect(3);
    compare_periods("load10");
  endtask
  task automatic test_min_clamp;
    ld = 1'b1;
    dv = 16'd0;
    @(negedge clk);
    ld = 1'b0;
    vec += 2;
    if (divo !== 16'd2) begin bad++; $display("FAIL clamp div: got %0d expected 2", divo); end
    if (locked !== 1'b0) begin bad++; $display("FAIL clamp locked: got %b expected 0", locked); end
    repeat (4) exp_q.push_back(2);
    collect(4);
    compare_periods("clamp");
  endtask
  task automatic test_autobaud(input logic p, input int b, input int exp_div);
    int e;
    pol = p;
    ser = ~p;
    repeat (10) @(negedge clk);
    ab = 1'b1;
    @(negedge clk);
    ab = 1'b0;
    vec++;
    if (busy !== 1'b1) begin bad++; $display("FAIL autobaud armed busy: got %b expected 1", busy); end
    exp_q.push_back(exp_div);
    repeat (5) @(negedge clk);
    send_frame(b, 8'h55);
    repeat (5) @(negedge clk);
    e = exp_q.pop_front();
    vec += 3;
    if (divo !== 16'(e)) begin bad++; $display("FAIL autobaud div: got %0d expected %0d", divo, e); end
    if (locked !== 1'b1) begin bad++; $display("FAIL autobaud locked: got %b expected 1", locked); end
    if (busy !== 1'b0) begin bad++; $display("FAIL autobaud busy: got %b expected 0", busy); end
    repeat (3) exp_q.push_back(exp_div);
    collect(3);
    compare_periods("autobaud");
  endtask
  task automatic test_abort;
    ab = 1'b1;
    @(negedge clk);
    ab = 1'b0;
    repeat (3) @(negedge clk);
    ser = pol;
    repeat (20) @(negedge clk);
    vec++;
    if (busy !== 1'b1) begin bad++; $display("FAIL abort pre busy: got %b expected 1", busy); end
    ld = 1'b1;
    dv = 16'd13;
    @(negedge clk);
    ld = 1'b0;
    vec += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort busy: got %b expected 0", busy); end
    if (divo !== 16'd13) begin bad++; $display("FAIL abort div: got %0d expected 13", divo); end
    if (locked !== 1'b0) begin bad++; $display("FAIL abort locked: got %b expected 0", locked); end
    ser = ~pol;
    repeat (5) @(negedge clk);
  endtask
  task automatic test_reset_mid;
    pol = 1'b0;
    ser = 1'b1;
    repeat (5) @(negedge clk);
    ab = 1'b1;
    @(negedge clk);
    ab = 1'b0;
    repeat (3) @(negedge clk);
    ser = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ser = 1'b1;
    vec += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL midreset busy: got %b expected 0", busy); end
    if (divo !== 16'd27) begin bad++; $display("FAIL midreset div: got %0d expected 27", divo); end
    if (locked !== 1'b0) begin bad++; $display("FAIL midreset locked: got %b expected 0", locked); end
    repeat (5) @(negedge clk);
  endtask
  task automatic test_timeout;
    int k;
    ab4 = 1'b1;
    @(negedge clk);
    ab4 = 1'b0;
    repeat (5) @(negedge clk);
    ser4 = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!to4 && k < 5000);
    vec++;
    if (k < 2049 || k > 2053) begin bad++; $display("FAIL timeout delay: got %0d cycles expected 2049..2053", k); end
    @(negedge clk);
    vec += 4;
    if (to4 !== 1'b0) begin bad++; $display("FAIL timeout width: got %b expected 0", to4); end
    if (div4 !== 4'd5) begin bad++; $display("FAIL timeout div: got %0d expected 5", div4); end
    if (locked4 !== 1'b0) begin bad++; $display("FAIL timeout locked: got %b expected 0", locked4); end
    if (busy4 !== 1'b0) begin bad++; $display("FAIL timeout busy: got %b expected 0", busy4); end
    ser4 = 1'b1;
  endtask
  initial begin
    test_reset;
    test_manual_load;
    test_min_clamp;
    test_autobaud(1'b0, 160, 10);
    test_abort;
    test_autobaud(1'b1, 432, 27);
    test_reset_mid;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
